// File: rtl/display_pkg.sv
// display_pkg: shared scan FSM states, segment width default and anode decode for the 7-segment scanner.
package display_pkg;
  localparam int SEG_W_DEF = 8;
  localparam int MAX_DIGITS = 32;
  typedef enum logic [1:0] {IDLE, BLANK, ON} scan_state_e;
  function automatic logic [MAX_DIGITS-1:0] anode_mask(input int unsigned idx, input int unsigned n);
    logic [MAX_DIGITS-1:0] m;
    m = '1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) if (i == idx && i < n) m[i] = 1'b0;
    return m;
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: per-digit slot counter emitting blank_done and slot_done strobes; held at 0 while not running.
module scan_prescaler #(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic blank_done,
  output logic slot_done
);
  localparam int CW = $clog2(TICKS_PER_DIGIT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign blank_done = cnt_q == CW'(BLANK_TICKS - 1);
  assign slot_done = cnt_q == CW'(TICKS_PER_DIGIT - 1);
  always_comb cnt_d = (!run || slot_done) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/anode_scanner.sv
// anode_scanner: multiplexed 7-segment anode/cathode driver with per-slot blanking and digit mask.
// Optional SCAN_DIM_EN adds a 16-step PWM brightness gate on the lit anode.
module anode_scanner
  import display_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS = 1000,
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [N_DIGITS-1:0]         digit_en,
  input  logic [N_DIGITS*SEG_W-1:0]   seg_in,
  input  logic [3:0]                  brightness,
  output logic [N_DIGITS-1:0]         anode,
  output logic [SEG_W-1:0]            cathode,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_tick
);
  localparam int IW = $clog2(N_DIGITS);
  scan_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SEG_W-1:0] seg_q, seg_d, cathode_q, cathode_d;
  logic [N_DIGITS-1:0] anode_q, anode_d, lit;
  logic frame_q, frame_d, blank_done, slot_done, gate, last;
`ifdef SCAN_DIM_EN
  logic [3:0] pwm_q;
  assign gate = brightness == 4'hF || pwm_q < brightness;
`else
  logic unused_bright;
  assign unused_bright = ^brightness;
  assign gate = 1'b1;
`endif
  scan_prescaler #(.TICKS_PER_DIGIT(TICKS_PER_DIGIT), .BLANK_TICKS(BLANK_TICKS)) u_pre (
    .clk(clk), .rst_n(rst_n), .run(enable && state_q != IDLE),
    .blank_done(blank_done), .slot_done(slot_done)
  );
  assign last = idx_q == IW'(N_DIGITS - 1);
  assign lit = (digit_en[idx_q] && gate) ? N_DIGITS'(anode_mask(32'(idx_q), N_DIGITS)) : '1;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    seg_d = seg_q;
    anode_d = '1;
    cathode_d = '1;
    frame_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d = '0;
    end else case (state_q)
      IDLE: state_d = BLANK;
      BLANK: if (blank_done) begin
        state_d = ON;
        anode_d = lit;
        cathode_d = ~seg_q;
      end
      ON: if (slot_done) begin
        state_d = BLANK;
        idx_d = last ? '0 : idx_q + 1'b1;
        frame_d = last;
      end else begin
        anode_d = lit;
        cathode_d = ~seg_q;
      end
      default: state_d = IDLE;
    endcase
    // segments are frozen on slot entry so mid-slot input changes never tear
    if (state_d == BLANK && state_q != BLANK) seg_d = seg_in[int'(idx_d)*SEG_W +: SEG_W];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      seg_q <= '0;
      anode_q <= '1;
      cathode_q <= '1;
      frame_q <= 1'b0;
`ifdef SCAN_DIM_EN
      pwm_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      anode_q <= anode_d;
      cathode_q <= cathode_d;
      frame_q <= frame_d;
`ifdef SCAN_DIM_EN
      pwm_q <= pwm_q + 1'b1;
`endif
    end
  assign anode = anode_q;
  assign cathode = cathode_q;
  assign digit_idx = idx_q;
  assign frame_tick = frame_q;
endmodule

// File: tb/tb_anode_scanner.sv
// tb_anode_scanner: directed timeline checks of anode_scanner with N=4, 8-tick slots, 2-tick blanking.
module tb_anode_scanner;
  logic clk = 1'b0;
  logic rst_n, enable, frame_tick;
  logic [3:0] digit_en, brightness, anode;
  logic [31:0] seg_in;
  logic [7:0] cathode, lat_m;
  logic [1:0] digit_idx;
  int checks = 0, errors = 0, k = 0, lit_n = 0;
  always #5 clk = ~clk;
  anode_scanner #(.N_DIGITS(4), .TICKS_PER_DIGIT(8), .BLANK_TICKS(2), .SEG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digit_en(digit_en), .seg_in(seg_in),
    .brightness(brightness), .anode(anode), .cathode(cathode), .digit_idx(digit_idx),
    .frame_tick(frame_tick)
  );
`ifdef SCAN_DIM_EN
  logic [3:0] pwm_m;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pwm_m <= 4'd0;
    else pwm_m <= pwm_m + 4'd1;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    int slot, pos;
    logic g;
    logic [3:0] ea;
    logic [7:0] ec;
    @(negedge clk);
    slot = (k / 8) % 4;
    pos = k % 8;
    if (pos == 0) lat_m = seg_in[slot*8 +: 8];
`ifdef SCAN_DIM_EN
    g = brightness == 4'hF || (pwm_m - 4'd1) < brightness;
`else
    g = 1'b1;
`endif
    ea = (pos >= 2 && digit_en[slot] && g) ? ~(4'b1 << slot) : 4'hF;
    ec = pos >= 2 ? ~lat_m : 8'hFF;
    check("anode", 32'(anode), 32'(ea));
    check("cathode", 32'(cathode), 32'(ec));
    check("idx", 32'(digit_idx), 32'(slot));
    check("frame", 32'(frame_tick), 32'(pos == 0 && slot == 0 && k > 0));
    check("onehot", 32'($countones(~anode) <= 1), 32'd1);
    if (anode != 4'hF) lit_n++;
    k++;
  endtask
  task automatic check_dark(input string tag);
    check({tag, "_anode"}, 32'(anode), 32'hF);
    check({tag, "_cathode"}, 32'(cathode), 32'hFF);
    check({tag, "_idx"}, 32'(digit_idx), 32'd0);
    check({tag, "_frame"}, 32'(frame_tick), 32'd0);
  endtask
  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    digit_en = 4'hF;
    brightness = 4'hF;
    seg_in = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    lat_m = 8'h00;
    repeat (2) @(negedge clk);
    check_dark("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_dark("idle");
    enable = 1'b1;
    k = 0;
    repeat (40) step();
    digit_en = 4'b1011;
    repeat (32) step();
    digit_en = 4'hF;
    repeat (4) step();
    seg_in[15:8] = 8'h66;
    step();
    check("seg_hold", 32'(cathode), 32'hF9);
    repeat (30) step();
    check("seg_new", 32'(cathode), 32'h99);
    repeat (8) step();
    check("slot2_on", 32'(anode), 32'hB);
    enable = 1'b0;
    @(negedge clk);
    check_dark("drop");
    repeat (3) @(negedge clk);
    check_dark("drop_hold");
    enable = 1'b1;
    k = 0;
    repeat (28) step();
    #2 rst_n = 1'b0;
    #1 check_dark("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    repeat (16) step();
`ifdef SCAN_DIM_EN
    brightness = 4'h4;
    repeat (32) step();
    brightness = 4'h0;
    lit_n = 0;
    repeat (32) step();
    check("dim_dark", lit_n, 32'd0);
    brightness = 4'hF;
    lit_n = 0;
    repeat (32) step();
    check("dim_full", lit_n, 32'd24);
`else
    brightness = 4'h0;
    lit_n = 0;
    repeat (32) step();
    check("full_duty", lit_n, 32'd24);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
